// File: rtl/top_mul_pipe_hs_if.sv
// Operand/result handshake bundle for top_mul_pipe_hs.
// slave = multiplier side, master = producer/consumer side.
interface top_mul_pipe_hs_if #(
    parameter int DIN0_WIDTH = 32,
    parameter int DIN1_WIDTH = 64,
    parameter int DOUT_WIDTH = 96
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_signed;
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic                  out_valid;
    logic                  out_ready;
    logic [DOUT_WIDTH-1:0] dout;
    logic                  out_ovf;

    modport slave (
        input  in_valid, in_signed, din0, din1, out_ready,
        output in_ready, out_valid, dout, out_ovf
    );

    modport master (
        output in_valid, in_signed, din0, din1, out_ready,
        input  in_ready, out_valid, dout, out_ovf
    );
endinterface

// File: rtl/top_mul_pipe_hs.sv
// Pipelined signed/unsigned multiplier with valid/ready handshake and bubble-collapsing stalls.
// Define MUL_PIPE_SAT_EN to saturate dout on overflow; otherwise dout wraps.
module top_mul_pipe_hs #(
    parameter int DIN0_WIDTH = 32,
    parameter int DIN1_WIDTH = 64,
    parameter int DOUT_WIDTH = 96,
    parameter int NUM_STAGE  = 3
) (
    input logic              clk,
    input logic              reset,
    top_mul_pipe_hs_if.slave bus
);
    localparam int P = DIN0_WIDTH + DIN1_WIDTH;

    logic [P-1:0]          a_ext, b_ext, prod;
    logic                  ovf_d;
    logic [DOUT_WIDTH-1:0] res_d;
    logic                  acc;

    assign a_ext = {{DIN1_WIDTH{bus.in_signed & bus.din0[DIN0_WIDTH-1]}}, bus.din0};
    assign b_ext = {{DIN0_WIDTH{bus.in_signed & bus.din1[DIN1_WIDTH-1]}}, bus.din1};
    // Modulo-2^P product of the extended operands is exact for both signednesses.
    assign prod  = a_ext * b_ext;

    generate
        if (DOUT_WIDTH == P) begin : g_full
            assign ovf_d = 1'b0;
        end else begin : g_narrow
            logic [P-DOUT_WIDTH:0] hi;
            assign hi    = prod[P-1:DOUT_WIDTH-1];
            assign ovf_d = bus.in_signed ? ~(&hi | ~|hi) : |hi[P-DOUT_WIDTH:1];
        end
    endgenerate

`ifdef MUL_PIPE_SAT_EN
    localparam logic [DOUT_WIDTH-1:0] SMIN = DOUT_WIDTH'(1) << (DOUT_WIDTH - 1);
    always_comb begin
        res_d = prod[DOUT_WIDTH-1:0];
        if (ovf_d) res_d = !bus.in_signed ? '1 : (prod[P-1] ? SMIN : ~SMIN);
    end
`else
    assign res_d = prod[DOUT_WIDTH-1:0];
`endif

    logic [NUM_STAGE-1:0]                 vld_q, vld_d, adv;
    logic [NUM_STAGE-1:0][DOUT_WIDTH-1:0] dat_q;
    logic [NUM_STAGE-1:0]                 ovf_q;

    // Flattened advance chain: stage i may load if any stage from i onward is empty,
    // or the sink is taking the head beat.
    for (genvar i = 0; i < NUM_STAGE; i++) begin : g_adv
        assign adv[i] = bus.out_ready | ~(&vld_q[NUM_STAGE-1:i]);
    end

    assign bus.in_ready = adv[0] & ~reset;
    assign acc          = bus.in_valid & bus.in_ready;

    always_comb begin
        vld_d = vld_q;
        if (adv[0]) vld_d[0] = acc;
        for (int i = 1; i < NUM_STAGE; i++)
            if (adv[i]) vld_d[i] = vld_q[i-1];
    end

    // Data moves only with a valid beat, so the output regs stay put across bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q              <= '0;
            dat_q[NUM_STAGE-1] <= '0;
            ovf_q[NUM_STAGE-1] <= 1'b0;
        end else begin
            vld_q <= vld_d;
            if (acc) begin
                dat_q[0] <= res_d;
                ovf_q[0] <= ovf_d;
            end
            for (int i = 1; i < NUM_STAGE; i++)
                if (adv[i] && vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                    ovf_q[i] <= ovf_q[i-1];
                end
        end
    end

    assign bus.out_valid = vld_q[NUM_STAGE-1];
    assign bus.dout      = dat_q[NUM_STAGE-1];
    assign bus.out_ovf   = ovf_q[NUM_STAGE-1];
endmodule

// File: tb/tb_top_mul_pipe_hs.sv
// Self-checking bench for top_mul_pipe_hs: 8x8->8 x3-stage instance plus a default-width instance.
// Expected results come from an integer-arithmetic model and a FIFO scoreboard.
module tb_top_mul_pipe_hs;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

`ifdef MUL_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    top_mul_pipe_hs_if #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(8)) s ();
    top_mul_pipe_hs_if w ();

    top_mul_pipe_hs #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(8), .NUM_STAGE(3)) u_s (
        .clk(clk), .reset(reset), .bus(s.slave));
    top_mul_pipe_hs u_w (.clk(clk), .reset(reset), .bus(w.slave));

    int n_chk = 0;
    int n_err = 0;
    int n_out = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: {ovf, dout} for the 8x8->8 instance, from plain integer arithmetic.
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic sg);
        longint pa, pb, p;
        logic [63:0] pu;
        logic ov;
        logic [7:0] d;
        pa = sg ? longint'($signed(a)) : longint'(a);
        pb = sg ? longint'($signed(b)) : longint'(b);
        p  = pa * pb;
        pu = p;
        ov = sg ? (p < -128 || p > 127) : (p > 255);
        d  = pu[7:0];
        if (SAT && ov) d = sg ? (p < 0 ? 8'h80 : 8'h7F) : 8'hFF;
        return {ov, d};
    endfunction

    // Scoreboard and stall-stability monitor, sampled on the falling edge.
    logic [8:0] q[$];
    bit         stall_prev = 1'b0;
    logic [7:0] p_dout;
    logic       p_ovf;
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
        end else begin
            if (stall_prev) begin
                chk("stall_vld", s.out_valid, 1'b1);
                chk("stall_dout", s.dout, p_dout);
                chk("stall_ovf", s.out_ovf, p_ovf);
            end
            if (s.out_valid && s.out_ready) begin
                if (q.size() == 0) chk("spurious_out", s.out_valid, 1'b0);
                else begin
                    logic [8:0] e;
                    e = q.pop_front();
                    chk("sb_dout", s.dout, e[7:0]);
                    chk("sb_ovf", s.out_ovf, e[8]);
                end
                n_out++;
            end
            if (s.in_valid && s.in_ready) q.push_back(model(s.din0, s.din1, s.in_signed));
        end
        stall_prev = !reset && s.out_valid && !s.out_ready;
        p_dout = s.dout;
        p_ovf  = s.out_ovf;
    end

    // Present one beat and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sg);
        bit fired = 1'b0;
        s.in_valid = 1'b1; s.din0 = a; s.din1 = b; s.in_signed = sg;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (s.in_ready) begin fired = 1'b1; break; end
        end
        if (!fired) chk("send_timeout", s.in_ready, 1'b1);
        @(posedge clk); #1;
        s.in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] ed, input logic eo);
        int k = 0;
        while (!s.out_valid && k < 20) begin @(negedge clk); k++; end
        chk({tag, "_vld"}, s.out_valid, 1'b1);
        chk({tag, "_dout"}, s.dout, ed);
        chk({tag, "_ovf"}, s.out_ovf, eo);
        @(posedge clk); #1;
    endtask

    task automatic latency(input string tag);
        int cyc = 1;
        while (!s.out_valid && cyc < 10) begin @(posedge clk); #1; cyc++; end
        chk(tag, cyc, 3);
    endtask

    task automatic wide(input string tag, input logic sg, input logic [31:0] a, input logic [63:0] b,
                        input logic [95:0] ed);
        int k = 0;
        w.in_valid = 1'b1; w.in_signed = sg; w.din0 = a; w.din1 = b;
        @(negedge clk);
        chk({tag, "_rdy"}, w.in_ready, 1'b1);
        @(posedge clk); #1;
        w.in_valid = 1'b0;
        while (!w.out_valid && k < 20) begin @(negedge clk); k++; end
        chk({tag, "_vld"}, w.out_valid, 1'b1);
        chk({tag, "_dout"}, w.dout, ed);
        chk({tag, "_ovf"}, w.out_ovf, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int idx, base;
        reset = 1'b1;
        s.in_valid = 1'b1; s.in_signed = 1'b0; s.din0 = 8'h12; s.din1 = 8'h34; s.out_ready = 1'b1;
        w.in_valid = 1'b0; w.in_signed = 1'b0; w.din0 = '0; w.din1 = '0; w.out_ready = 1'b1;

        // Reset held two cycles with in_valid asserted.
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", s.out_valid, 1'b0);
        chk("rst_dout", s.dout, 8'h00);
        chk("rst_ovf", s.out_ovf, 1'b0);
        chk("rst_in_ready", s.in_ready, 1'b0);
        chk("rst_w_valid", w.out_valid, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0; s.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); chk("rst_no_beat", s.out_valid, 1'b0); end
        @(posedge clk); #1;

        // Latency and basic products.
        send(8'h0F, 8'h0F, 1'b0);
        latency("lat_0f");
        expect_out("mul_0f", 8'hE1, 1'b0);
        send(8'h80, 8'h02, 1'b1);
        expect_out("sgn_ovf", SAT ? 8'h80 : 8'h00, 1'b1);
        send(8'hFF, 8'hFF, 1'b0);
        expect_out("uns_ovf", SAT ? 8'hFF : 8'h01, 1'b1);
        send(8'hF6, 8'h0C, 1'b1);
        expect_out("sgn_ok", 8'h88, 1'b0);

        // Backpressure: sink stalled while six beats are offered.
        s.out_ready = 1'b0;
        idx = 0; base = n_out;
        for (int c = 0; c < 40 && idx < 6; c++) begin
            bit f;
            if (c == 6) begin
                chk("bp_accepts", idx, 3);
                chk("bp_in_ready", s.in_ready, 1'b0);
                s.out_ready = 1'b1;
            end
            s.in_valid = 1'b1; s.in_signed = 1'b0; s.din0 = 8'(10 + idx); s.din1 = 8'(3 + idx);
            @(negedge clk);
            f = s.in_ready;
            @(posedge clk); #1;
            if (f) idx++;
        end
        s.in_valid = 1'b0;
        for (int k = 0; k < 20 && n_out - base < 6; k++) @(posedge clk);
        #1;
        chk("bp_emitted", n_out - base, 6);

        // Randomised traffic with random sink stalls.
        for (int c = 0; c < 600; c++) begin
            s.in_valid  = ($urandom_range(0, 9) < 7);
            s.out_ready = ($urandom_range(0, 9) < 6);
            s.in_signed = 1'($urandom);
            s.din0      = 8'($urandom);
            s.din1      = 8'($urandom);
            @(posedge clk); #1;
        end
        s.in_valid = 1'b0; s.out_ready = 1'b1;
        for (int k = 0; k < 20 && q.size() != 0; k++) begin @(posedge clk); #1; end
        chk("drain_empty", q.size(), 0);

        // Reset with two beats in flight.
        send(8'h11, 8'h03, 1'b0);
        send(8'h22, 8'h03, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin @(negedge clk); chk("midrst_flush", s.out_valid, 1'b0); end
        @(posedge clk); #1;
        send(8'h05, 8'h07, 1'b0);
        latency("midrst_lat");
        expect_out("midrst_beat", 8'h23, 1'b0);

        // Full-width instance.
        wide("w_sgn", 1'b1, '1, '1, 96'd1);
        wide("w_uns", 1'b0, '1, '1, 96'hFFFFFFFE_FFFFFFFF_00000001);
        wide("w_mix", 1'b1, 32'hFFFF_FFFE, 64'd3, 96'hFFFFFFFF_FFFFFFFF_FFFFFFFA);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
